// File: rtl/qe_m_scheduler.sv
// qe_m_scheduler: round-robin share of one QE_M unit between NUM_REQ
// requesters. MAC bursts hold the grant until their last beat; each
// result is tagged with its owner through an in-order tag FIFO.
// Ports: clk, reset (async, active-low); req_valid/ready/mode/last and
// packed req_a/b/c/x per requester; qe_* issue register to QE_M;
// qe_valid_out/qe_result back from QE_M; rsp_valid/id/result routed
// result; busy (lock held or tags outstanding); err sticky error.
// Build option: define QE_SCHED_ERR_EN to enable err, else err is 0.
module qe_m_scheduler #(
    parameter  int NUM_REQ   = 4,
    parameter  int TAG_DEPTH = 4,
    localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
    localparam int AW   = (TAG_DEPTH > 1) ? $clog2(TAG_DEPTH) : 1,
    localparam int CW   = AW + 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_REQ-1:0]   req_valid,
    output logic [NUM_REQ-1:0]   req_ready,
    input  logic [NUM_REQ-1:0]   req_mode,
    input  logic [NUM_REQ-1:0]   req_last,
    input  logic [8*NUM_REQ-1:0] req_a,
    input  logic [8*NUM_REQ-1:0] req_b,
    input  logic [8*NUM_REQ-1:0] req_c,
    input  logic [8*NUM_REQ-1:0] req_x,
    output logic                 qe_valid_in,
    output logic                 qe_mode,
    output logic                 qe_last_input,
    output logic [7:0]           qe_a,
    output logic [7:0]           qe_b,
    output logic [7:0]           qe_c,
    output logic [7:0]           qe_x,
    input  logic                 qe_valid_out,
    input  logic [15:0]          qe_result,
    output logic                 rsp_valid,
    output logic [ID_W-1:0]      rsp_id,
    output logic [15:0]          rsp_result,
    output logic                 busy,
    output logic                 err
);

    typedef enum logic {UNLOCKED, LOCKED} state_t;

    state_t state_q, state_d;

    logic [ID_W-1:0]    lock_q;
    logic [ID_W-1:0]    ptr_q;
    logic [ID_W-1:0]    win_id;
    logic [ID_W-1:0]    cand;
    logic               win_found;
    logic               win_mode;
    logic               win_last;
    logic [ID_W+2:0]    sel;
    logic [NUM_REQ-1:0] elig;
    int                 idx;

    logic [ID_W-1:0] tag_mem [TAG_DEPTH];
    logic [AW-1:0]   wr_q;
    logic [AW-1:0]   rd_q;
    logic [CW-1:0]   cnt_q;
    logic            full;
    logic            empty;
    logic            push;
    logic            pop;

    assign full  = (cnt_q == CW'(TAG_DEPTH));
    assign empty = (cnt_q == '0);

    // Producing beats need a free tag slot; mid-burst MAC beats do not.
    // While locked only the owner may go, and only with MAC beats.
    always_comb begin
        elig = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            elig[i] = req_valid[i];
            if (state_q == LOCKED) begin
                if (ID_W'(i) != lock_q || !req_mode[i])
                    elig[i] = 1'b0;
            end
            if ((!req_mode[i] || req_last[i]) && full)
                elig[i] = 1'b0;
        end
    end

    // Rotating priority: search starts just after the last winner.
    always_comb begin
        win_found = 1'b0;
        win_id    = '0;
        cand      = '0;
        idx       = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx  = (int'(ptr_q) + k) % NUM_REQ;
            cand = ID_W'(idx);
            if (!win_found && elig[cand]) begin
                win_found = 1'b1;
                win_id    = cand;
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (win_found && reset)
            req_ready[win_id] = 1'b1;
    end

    assign win_mode = req_mode[win_id];
    assign win_last = req_last[win_id];
    assign sel      = {win_id, 3'b000};
    assign push     = win_found && (!win_mode || win_last);
    assign pop      = qe_valid_out && !empty;
    assign busy     = (state_q == LOCKED) || !empty;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            UNLOCKED:
                if (win_found && win_mode && !win_last)
                    state_d = LOCKED;
            LOCKED:
                if (win_found && win_last)
                    state_d = UNLOCKED;
            default:
                state_d = UNLOCKED;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= UNLOCKED;
            lock_q  <= '0;
            ptr_q   <= ID_W'(NUM_REQ - 1);
        end else begin
            state_q <= state_d;
            if (win_found) begin
                ptr_q  <= win_id;
                lock_q <= win_id;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            tag_mem[wr_q] <= win_id;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (push)
                wr_q <= wr_q + AW'(1);
            if (pop)
                rd_q <= rd_q + AW'(1);
            if (push && !pop)
                cnt_q <= cnt_q + CW'(1);
            else if (pop && !push)
                cnt_q <= cnt_q - CW'(1);
        end
    end

    // Issue register: operands hold their last values when idle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            qe_valid_in   <= 1'b0;
            qe_mode       <= 1'b0;
            qe_last_input <= 1'b0;
            qe_a          <= '0;
            qe_b          <= '0;
            qe_c          <= '0;
            qe_x          <= '0;
        end else begin
            qe_valid_in <= win_found;
            if (win_found) begin
                qe_mode       <= win_mode;
                qe_last_input <= win_mode && win_last;
                qe_a          <= req_a[sel +: 8];
                qe_b          <= req_b[sel +: 8];
                qe_c          <= req_c[sel +: 8];
                qe_x          <= req_x[sel +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rsp_valid  <= 1'b0;
            rsp_id     <= '0;
            rsp_result <= '0;
        end else begin
            rsp_valid <= pop;
            if (pop) begin
                rsp_id     <= tag_mem[rd_q];
                rsp_result <= qe_result;
            end
        end
    end

`ifdef QE_SCHED_ERR_EN
    logic err_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            err_q <= 1'b0;
        end else if ((qe_valid_out && empty) ||
                     (state_q == LOCKED &&
                      req_valid[lock_q] &&
                      !req_mode[lock_q])) begin
            err_q <= 1'b1;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_qe_m_scheduler.sv
// tb_qe_m_scheduler: scoreboard bench for qe_m_scheduler with an
// in-order QE_M model that can withhold or inject results.
module tb_qe_m_scheduler;

    localparam int N = 4;

`ifdef QE_SCHED_ERR_EN
    localparam int ERR_EXP = 1;
`else
    localparam int ERR_EXP = 0;
`endif

    logic           clk = 1'b0;
    logic           reset;
    logic [N-1:0]   req_valid;
    logic [N-1:0]   req_ready;
    logic [N-1:0]   req_mode;
    logic [N-1:0]   req_last;
    logic [8*N-1:0] req_a;
    logic [8*N-1:0] req_b;
    logic [8*N-1:0] req_c;
    logic [8*N-1:0] req_x;
    logic           qe_valid_in;
    logic           qe_mode;
    logic           qe_last_input;
    logic [7:0]     qe_a;
    logic [7:0]     qe_b;
    logic [7:0]     qe_c;
    logic [7:0]     qe_x;
    logic           qe_valid_out;
    logic [15:0]    qe_result;
    logic           rsp_valid;
    logic [1:0]     rsp_id;
    logic [15:0]    rsp_result;
    logic           busy;
    logic           err;

    qe_m_scheduler #(.NUM_REQ(N), .TAG_DEPTH(4)) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_mode     (req_mode),
        .req_last     (req_last),
        .req_a        (req_a),
        .req_b        (req_b),
        .req_c        (req_c),
        .req_x        (req_x),
        .qe_valid_in  (qe_valid_in),
        .qe_mode      (qe_mode),
        .qe_last_input(qe_last_input),
        .qe_a         (qe_a),
        .qe_b         (qe_b),
        .qe_c         (qe_c),
        .qe_x         (qe_x),
        .qe_valid_out (qe_valid_out),
        .qe_result    (qe_result),
        .rsp_valid    (rsp_valid),
        .rsp_id       (rsp_id),
        .rsp_result   (rsp_result),
        .busy         (busy),
        .err          (err)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp)
            n_pass++;
        else
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    endtask

    function automatic int quad(input int a, input int b,
                                input int c, input int x);
        return (a * x * x + b * x + c) & 32'hFFFF;
    endfunction

    // Scoreboard side: expected (id, result) from driven stimulus.
    int         sb_id[$];
    int         sb_res[$];
    int         grant_log[$];
    int         sb_acc[N];
    int         last_res[N];
    logic [N-1:0] acc_now;

    always @(negedge clk) begin
        if (!reset) begin
            sb_id.delete();
            sb_res.delete();
            for (int i = 0; i < N; i++) sb_acc[i] = 0;
            acc_now = '0;
        end else begin
            if (rsp_valid) begin
                if (sb_id.size() == 0) begin
                    check("rsp_without_expect", int'(rsp_result), -1);
                end else begin
                    check("rsp_id", int'(rsp_id), sb_id.pop_front());
                    check("rsp_result", int'(rsp_result),
                          sb_res.pop_front());
                    last_res[rsp_id] = int'(rsp_result);
                end
            end
            acc_now = req_valid & req_ready;
            for (int i = 0; i < N; i++) begin
                if (acc_now[i]) begin
                    int a, b, c, x;
                    a = int'(req_a[8*i +: 8]);
                    b = int'(req_b[8*i +: 8]);
                    c = int'(req_c[8*i +: 8]);
                    x = int'(req_x[8*i +: 8]);
                    grant_log.push_back(i);
                    if (!req_mode[i]) begin
                        sb_id.push_back(i);
                        sb_res.push_back(quad(a, b, c, x));
                    end else begin
                        sb_acc[i] = (sb_acc[i] + a * x) & 32'hFFFF;
                        if (req_last[i]) begin
                            sb_id.push_back(i);
                            sb_res.push_back(sb_acc[i]);
                            sb_acc[i] = 0;
                        end
                    end
                end
            end
        end
    end

    // QE_M model: in-order, optional hold with single-result credits.
    int   pipe[$];
    int   m_acc;
    logic qe_hold;
    int   credit_req;
    int   credit_used = 0;
    int   inject_req;
    int   inject_done = 0;

    always @(negedge clk) begin
        if (!reset) begin
            pipe.delete();
            m_acc        = 0;
            qe_valid_out = 1'b0;
            qe_result    = '0;
        end else begin
            if (qe_valid_in) begin
                if (!qe_mode) begin
                    pipe.push_back(quad(int'(qe_a), int'(qe_b),
                                        int'(qe_c), int'(qe_x)));
                end else begin
                    m_acc = (m_acc + int'(qe_a) * int'(qe_x)) & 32'hFFFF;
                    if (qe_last_input) begin
                        pipe.push_back(m_acc);
                        m_acc = 0;
                    end
                end
            end
            qe_valid_out = 1'b0;
            qe_result    = '0;
            if (inject_req != inject_done) begin
                inject_done++;
                qe_valid_out = 1'b1;
                qe_result    = 16'hBEEF;
            end else if (pipe.size() > 0 &&
                         (!qe_hold || credit_req != credit_used)) begin
                if (qe_hold) credit_used++;
                qe_valid_out = 1'b1;
                qe_result    = 16'(pipe.pop_front());
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: time %0t exceeded limit", $time);
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        req_valid = '0;
        req_mode  = '0;
        req_last  = '0;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        idle_inputs();
        repeat (2) tick();
        reset = 1'b1;
        tick();
    endtask

    task automatic set_beat(input int i, input int a, input int b,
                            input int c, input int x,
                            input logic m, input logic l);
        req_a[8*i +: 8] = 8'(a);
        req_b[8*i +: 8] = 8'(b);
        req_c[8*i +: 8] = 8'(c);
        req_x[8*i +: 8] = 8'(x);
        req_mode[i]     = m;
        req_last[i]     = l;
    endtask

    task automatic next_beat(input int i);
        req_a[8*i +: 8] = req_a[8*i +: 8] + 8'd37;
        req_b[8*i +: 8] = req_b[8*i +: 8] + 8'd11;
        req_c[8*i +: 8] = req_c[8*i +: 8] + 8'd3;
        req_x[8*i +: 8] = req_x[8*i +: 8] + 8'd5;
    endtask

    task automatic drain(input string tag);
        int k;
        for (k = 0; k < 100; k++) begin
            tick();
            if (sb_id.size() == 0 && pipe.size() == 0 && !busy) break;
        end
        check({tag, "_drain"}, int'(k < 100), 1);
    endtask

    initial begin
        int g0;
        int done;
        int exp_rr[3];
        exp_rr = '{0, 2, 3};
        reset      = 1'b1;
        qe_hold    = 1'b0;
        credit_req = 0;
        inject_req = 0;
        req_a = '0;
        req_b = '0;
        req_c = '0;
        req_x = '0;
        idle_inputs();
        #1 reset = 1'b0;
        req_valid = '1;
        #2;
        check("rst_ready", int'(req_ready), 0);
        check("rst_qe_valid", int'(qe_valid_in), 0);
        check("rst_qe_a", int'(qe_a), 0);
        check("rst_rsp_valid", int'(rsp_valid), 0);
        check("rst_rsp_result", int'(rsp_result), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_err", int'(err), 0);
        idle_inputs();
        repeat (2) tick();
        reset = 1'b1;
        tick();

        // Single quadratic from requester 1.
        set_beat(1, 100, 5, 25, 8, 1'b0, 1'b0);
        req_valid = 4'b0010;
        @(negedge clk);
        check("quad_ready", int'(req_ready), 4'b0010);
        tick();
        req_valid = '0;
        @(negedge clk);
        check("quad_issue_valid", int'(qe_valid_in), 1);
        check("quad_issue_a", int'(qe_a), 100);
        check("quad_issue_x", int'(qe_x), 8);
        @(negedge clk);
        check("quad_rsp_valid", int'(rsp_valid), 1);
        check("quad_rsp_id", int'(rsp_id), 1);
        check("quad_rsp_res", int'(rsp_result), 6465);
        drain("quad");

        // Round-robin among 0, 2, 3.
        do_reset();
        set_beat(0, 1, 2, 3, 4, 1'b0, 1'b0);
        set_beat(2, 21, 22, 23, 24, 1'b0, 1'b0);
        set_beat(3, 31, 32, 33, 34, 1'b0, 1'b0);
        g0 = grant_log.size();
        req_valid = 4'b1101;
        done = 0;
        for (int t = 0; t < 40; t++) begin
            tick();
            for (int i = 0; i < N; i++)
                if (acc_now[i]) next_beat(i);
            if (grant_log.size() - g0 >= 9) begin
                done = 1;
                break;
            end
        end
        req_valid = '0;
        check("rr_done", done, 1);
        for (int k = 0; k < 9; k++)
            if (g0 + k < grant_log.size())
                check("rr_grant", grant_log[g0 + k], exp_rr[k % 3]);
        drain("rr");

        // MAC burst from 2 with an idle gap; 0 waits.
        do_reset();
        set_beat(2, 100, 0, 0, 8, 1'b1, 1'b0);
        req_valid = 4'b0100;
        @(negedge clk);
        check("mac_b0_ready", int'(req_ready), 4'b0100);
        tick();
        set_beat(0, 7, 1, 2, 3, 1'b0, 1'b0);
        req_valid = 4'b0001;
        @(negedge clk);
        check("mac_gap_ready", int'(req_ready), 0);
        check("mac_gap_busy", int'(busy), 1);
        tick();
        set_beat(2, 20, 0, 0, 3, 1'b1, 1'b0);
        req_valid = 4'b0101;
        @(negedge clk);
        check("mac_gap_qe_idle", int'(qe_valid_in), 0);
        check("mac_b1_ready", int'(req_ready), 4'b0100);
        tick();
        set_beat(2, 1, 0, 0, 2, 1'b1, 1'b1);
        @(negedge clk);
        check("mac_b2_ready", int'(req_ready), 4'b0100);
        tick();
        req_valid = 4'b0001;
        @(negedge clk);
        check("mac_release", int'(req_ready), 4'b0001);
        tick();
        req_valid = '0;
        drain("mac");
        check("mac_result", last_res[2], 862);

        // Tag FIFO full: withheld results block the fifth beat.
        do_reset();
        qe_hold = 1'b1;
        set_beat(0, 10, 20, 30, 2, 1'b0, 1'b0);
        g0 = grant_log.size();
        req_valid = 4'b0001;
        done = 0;
        for (int t = 0; t < 20; t++) begin
            tick();
            if (acc_now[0]) next_beat(0);
            if (grant_log.size() - g0 >= 4) begin
                done = 1;
                break;
            end
        end
        check("full_fill", done, 1);
        @(negedge clk);
        check("full_block", int'(req_ready), 0);
        tick();
        @(negedge clk);
        check("full_block2", int'(req_ready), 0);
        check("full_busy", int'(busy), 1);
        tick();
        credit_req++;
        @(negedge clk);
        check("full_no_bypass", int'(req_ready), 0);
        tick();
        @(negedge clk);
        check("full_refill", int'(req_ready), 4'b0001);
        tick();
        req_valid = '0;
        check("full_count", grant_log.size() - g0, 5);
        qe_hold = 1'b0;
        drain("full");

        // Result with no outstanding tag.
        do_reset();
        inject_req++;
        @(negedge clk);
        @(negedge clk);
        check("orphan_rsp_valid", int'(rsp_valid), 0);
        check("orphan_err", int'(err), ERR_EXP);
        tick();

        // Quadratic beat from the lock owner stalls.
        do_reset();
        check("err_after_reset", int'(err), 0);
        set_beat(3, 9, 0, 0, 9, 1'b1, 1'b0);
        req_valid = 4'b1000;
        @(negedge clk);
        check("lk_b0_ready", int'(req_ready), 4'b1000);
        tick();
        set_beat(3, 4, 4, 4, 4, 1'b0, 1'b0);
        @(negedge clk);
        check("lk_mode0_stall", int'(req_ready), 0);
        tick();
        @(negedge clk);
        check("lk_mode0_stall2", int'(req_ready), 0);
        check("lk_err", int'(err), ERR_EXP);
        tick();
        set_beat(3, 2, 0, 0, 5, 1'b1, 1'b1);
        @(negedge clk);
        check("lk_last_ready", int'(req_ready), 4'b1000);
        tick();
        req_valid = '0;
        drain("lk");
        check("lk_result", last_res[3], 91);

        // Reset in the middle of a requester-1 burst.
        do_reset();
        set_beat(1, 3, 0, 0, 4, 1'b1, 1'b0);
        req_valid = 4'b0010;
        tick();
        set_beat(1, 5, 0, 0, 6, 1'b1, 1'b0);
        tick();
        #2 reset = 1'b0;
        #1;
        check("mid_rst_qe_valid", int'(qe_valid_in), 0);
        check("mid_rst_qe_mode", int'(qe_mode), 0);
        check("mid_rst_qe_a", int'(qe_a), 0);
        check("mid_rst_busy", int'(busy), 0);
        check("mid_rst_ready", int'(req_ready), 0);
        check("mid_rst_rsp", int'(rsp_valid), 0);
        idle_inputs();
        repeat (2) tick();
        reset = 1'b1;
        set_beat(0, 6, 1, 1, 2, 1'b0, 1'b0);
        set_beat(1, 8, 1, 1, 3, 1'b0, 1'b0);
        req_valid = 4'b0011;
        @(negedge clk);
        check("post_rst_prio", int'(req_ready), 4'b0001);
        check("post_rst_busy", int'(busy), 0);
        tick();
        req_valid = 4'b0010;
        tick();
        req_valid = '0;
        drain("post_rst");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/qe_m_scheduler.md
# qe_m_scheduler

Round-robin scheduler that shares one QE_M quadratic/MAC unit between NUM_REQ requesters. It sits between requesters and QE_M, and registers one operand beat per cycle into the unit. MAC bursts keep the grant until their last beat. Each QE_M result is tagged with its owner and returned to that requester.

## Interface
- NUM_REQ, 4: number of requesters (2..8); ID_W = clog2(NUM_REQ), min 1
- TAG_DEPTH, 4: outstanding-result tag FIFO depth (power of 2)
- clk  in  1  clock, rising edge
- reset  in  1  one clock; reset is asynchronous and active-low
- req_valid  in  NUM_REQ  per-requester beat valid
- req_ready  out  NUM_REQ  per-requester accept, combinational
- req_mode  in  NUM_REQ  0 = quadratic a·x²+b·x+c, 1 = MAC Σa·x
- req_last  in  NUM_REQ  final beat of a MAC burst (ignored when mode=0)
- req_a, req_b, req_c, req_x  in  8·NUM_REQ each  packed operands, requester i at [8i+7:8i]
- qe_valid_in, qe_mode, qe_last_input  out  1  to QE_M
- qe_a, qe_b, qe_c, qe_x  out  8 each  to QE_M
- qe_valid_out  in  1; qe_result  in  16  from QE_M
- rsp_valid  out  1; rsp_id  out  ID_W; rsp_result  out  16  routed result
- busy  out  1  lock held or tag FIFO non-empty
- err  out  1  sticky protocol error (see Configuration)

## Operation
- Accept i = req_valid[i] & req_ready[i]. At most one accept per cycle.
- Producing beat: a mode=0 beat, or a mode=1 beat with last=1. Each producing beat pushes i into the tag FIFO.
- req_ready[i] is high only for the arbitration winner.
  - Blocked for a producing beat when FIFO count == TAG_DEPTH. There is no same-cycle pop bypass.
  - Non-producing MAC beats ignore the FIFO level.
- Arbitration: rotating priority, starting at ptr+1 modulo NUM_REQ. ptr ← winner on every accept.
- States:
  - UNLOCKED: all valid requesters compete.
    - Accepting mode=1, last=0 from i → LOCKED(i).
    - Accepting mode=1, last=1 is a single-beat burst; stay UNLOCKED.
  - LOCKED(i): only requester i may be granted.
    - Other requesters stall.
    - If i is idle, qe_valid_in=0 that cycle and the lock is held.
    - A mode=0 beat from i is not accepted (stall).
    - Accepting i's mode=1, last=1 beat → UNLOCKED.
- Issue register: on accept, qe_* ← winner's beat with qe_valid_in=1. Otherwise qe_valid_in=0 and qe_mode/qe_last_input/operands hold their values.
- Return: on qe_valid_out, pop the FIFO head and register rsp_valid=1, rsp_id=head, rsp_result=qe_result.
- Push and pop in the same cycle are allowed; count is unchanged.
- qe_valid_out with an empty FIFO: the result is dropped and rsp_valid stays 0.

## Timing
- Reset (asserted low, asynchronous) forces:
  - qe_valid_in, qe_mode, qe_last_input, and all qe operands to 0.
  - rsp_valid, rsp_id, rsp_result, busy, err to 0.
  - req_ready to 0 while reset is asserted.
  - State to UNLOCKED, FIFO empty, ptr = NUM_REQ-1 (requester 0 has first priority).
- Reset mid-burst drops the lock and all outstanding tags. Late qe_valid_out after reset falls under the empty-FIFO rule.
- Latency: accept in cycle N → qe_valid_in high in N+1. qe_valid_out in cycle M → rsp_valid in M+1.
- Throughput: one beat per cycle. Results return in issue order, so QE_M must be in-order.

## Configuration
- QE_SCHED_ERR_EN defined:
  - err sets on qe_valid_out with an empty FIFO.
  - err sets on a mode=0 req_valid from the locked requester.
  - err clears only on reset.
- Not defined: err is tied to 0 and both events are silent (drop / stall).

## Test plan
- Single quadratic: requester 1 sends a=100, b=5, c=25, x=8, mode 0 → qe_valid_in next cycle; rsp_valid with rsp_id=1, rsp_result=6465.
- Round-robin: requesters 0, 2, 3 hold mode-0 beats continuously → grants 0, 2, 3, 0, 2, 3…; rsp_id order matches the grant order.
- MAC lock: requester 2 sends (100,8), idle one cycle, (20,3), (1,2 last) while requester 0 is valid.
  - Requester 0 is not granted until after the last beat.
  - rsp_id=2, rsp_result=862.
  - One idle qe cycle appears during the gap.
- FIFO full: QE_M model withholds qe_valid_out; issue 5 mode-0 beats → 4 accepted, 5th req_ready=0. One pop → 5th accepted the following cycle.
- Errors (with QE_SCHED_ERR_EN): qe_valid_out pulse with no outstanding tag → rsp_valid stays 0 and err=1. Mode-0 beat from the locked requester → stalled and err=1.
- Reset mid-burst: drop reset low during a requester-1 MAC burst → all outputs 0 asynchronously. After release, requester 0 wins first and busy=0.
